mat_row_collector: RTL and testbench

Row-serial to full-matrix collector, the write-back end of the matrix multiplier datapath. Accepts one ROW_W-bit result row per accepted handshake, assembles ROWS rows into a single flat matrix word, and presents the whole matrix once complete. Its output layout is exactly the layout the row-serial matrix loader consumes: row 0 in the lowest-indexed slice. A collected matrix can therefore be fed straight back into the loader.

---
 rtl/mat_row_collector_if.sv | 25 ++
 rtl/mat_row_collector.sv | 44 ++++
 tb/tb_mat_row_collector.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mat_row_collector_if.sv
// mat_row_collector_if: row-in / matrix-out handshake bundle for the row collector
// master (producer/consumer side): drives clear, in_valid, in_row, out_ready
// slave (collector side): drives in_ready, out_valid, out_matrix, row_count
interface mat_row_collector_if #(
  parameter int ROW_W = 2048,
  parameter int ROWS  = 128,
  parameter int CNT_W = $clog2(ROWS + 1)
);
  logic                  clear;
  logic                  in_valid;
  logic [0:ROW_W-1]      in_row;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:ROWS*ROW_W-1] out_matrix;
  logic [CNT_W-1:0]      row_count;
  modport master (
    output clear, in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_matrix, row_count
  );
  modport slave (
    input  clear, in_valid, in_row, out_ready,
    output in_ready, out_valid, out_matrix, row_count
  );
endinterface

// File: rtl/mat_row_collector.sv
// mat_row_collector: assembles ROWS row-serial inputs into one flat matrix, row 0 in the lowest-indexed slice
// clk, rst_n (async, active-low); bus: slave side of mat_row_collector_if
module mat_row_collector #(
  parameter int ROW_W = 2048,
  parameter int ROWS  = 128,
  parameter int CNT_W = $clog2(ROWS + 1)
) (
  input logic                clk,
  input logic                rst_n,
  mat_row_collector_if.slave bus
);
  localparam int IDX_W = $clog2(ROWS);
  typedef enum logic {FILL, FULL} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [0:ROW_W-1] r_rows [ROWS];
  // in_ready/out_valid decode only from state, so neither in_valid nor out_ready reaches an output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
      for (int i = 0; i < ROWS; i++) r_rows[i] <= '0;
    end else if (bus.clear) begin
      r_state <= FILL;
      r_cnt   <= '0;
      for (int i = 0; i < ROWS; i++) r_rows[i] <= '0;
    end else if (r_state == FILL) begin
      if (bus.in_valid) begin
        r_rows[r_cnt[IDX_W-1:0]] <= bus.in_row;
        r_cnt   <= r_cnt + CNT_W'(1);
        r_state <= (r_cnt == CNT_W'(ROWS - 1)) ? FULL : FILL;
      end
    end else if (bus.out_ready) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end
  end
  assign bus.in_ready  = (r_state == FILL);
  assign bus.out_valid = (r_state == FULL);
  assign bus.row_count = r_cnt;
  for (genvar k = 0; k < ROWS; k++) begin : g_slot
    assign bus.out_matrix[k*ROW_W +: ROW_W] = r_rows[k];
  end
endmodule

// File: tb/tb_mat_row_collector.sv
// tb_mat_row_collector: directed and randomized checks of mat_row_collector (small 8x4 and full 2048x128 instances)
module tb_mat_row_collector;
  localparam int SW = 8;
  localparam int SR = 4;
  localparam int BW = 2048;
  localparam int BR = 128;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  mat_row_collector_if #(.ROW_W(SW), .ROWS(SR)) sb ();
  mat_row_collector_if #(.ROW_W(BW), .ROWS(BR)) bb ();
  mat_row_collector #(.ROW_W(SW), .ROWS(SR)) u_small (.clk(clk), .rst_n(rst_n), .bus(sb.slave));
  mat_row_collector #(.ROW_W(BW), .ROWS(BR)) u_big (.clk(clk), .rst_n(rst_n), .bus(bb.slave));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_small_idle(input string tag);
    total++; if (sb.in_ready !== 1'b1) $display("FAIL %s in_ready got %b want 1", tag, sb.in_ready); else passed++;
    total++; if (sb.out_valid !== 1'b0) $display("FAIL %s out_valid got %b want 0", tag, sb.out_valid); else passed++;
    total++; if (sb.row_count !== 3'd0) $display("FAIL %s row_count got %0d want 0", tag, sb.row_count); else passed++;
    total++; if (sb.out_matrix !== 32'h0) $display("FAIL %s out_matrix got %h want 0", tag, sb.out_matrix); else passed++;
  endtask
  task automatic test_reset;
    #12;
    check_small_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_back_to_back;
    logic [0:4*SW-1] rows;
    rows = 32'hA1B2C3D4;
    for (int i = 0; i < 4; i++) begin
      sb.in_valid = 1'b1;
      sb.in_row = rows[i*8 +: 8];
      tick();
      total++; if (sb.row_count !== 3'(i + 1)) $display("FAIL b2b_count%0d got %0d want %0d", i, sb.row_count, i + 1); else passed++;
    end
    sb.in_valid = 1'b0;
    total++; if (sb.out_valid !== 1'b1) $display("FAIL b2b_out_valid got %b want 1", sb.out_valid); else passed++;
    total++; if (sb.in_ready !== 1'b0) $display("FAIL b2b_in_ready got %b want 0", sb.in_ready); else passed++;
    total++; if (sb.out_matrix !== 32'hA1B2C3D4) $display("FAIL b2b_matrix got %h want A1B2C3D4", sb.out_matrix); else passed++;
  endtask
  task automatic test_backpressure;
    sb.in_valid = 1'b1;
    sb.in_row = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (sb.out_matrix !== 32'hA1B2C3D4 || sb.out_valid !== 1'b1 || sb.row_count !== 3'd4)
        $display("FAIL bp_hold%0d got %h/%b/%0d want A1B2C3D4/1/4", i, sb.out_matrix, sb.out_valid, sb.row_count); else passed++;
    end
    sb.out_ready = 1'b1;
    tick();
    sb.out_ready = 1'b0;
    total++; if (sb.out_valid !== 1'b0 || sb.row_count !== 3'd0)
      $display("FAIL bp_drain got valid %b count %0d want 0/0", sb.out_valid, sb.row_count); else passed++;
    tick();
    sb.in_valid = 1'b0;
    total++; if (sb.row_count !== 3'd1 || sb.out_matrix[0:7] !== 8'hEE)
      $display("FAIL bp_row0 got count %0d row0 %h want 1/EE", sb.row_count, sb.out_matrix[0:7]); else passed++;
  endtask
  task automatic test_gapped;
    sb.clear = 1'b1;
    tick();
    sb.clear = 1'b0;
    total++; if (sb.row_count !== 3'd0) $display("FAIL gap_clear got %0d want 0", sb.row_count); else passed++;
    for (int i = 0; i < 8; i++) begin
      sb.in_valid = (i % 2 == 0);
      sb.in_row = (i % 2 == 0) ? 8'(i / 2 + 1) : 8'($urandom);
      tick();
      total++; if (sb.row_count !== 3'(i / 2 + 1)) $display("FAIL gap_count%0d got %0d want %0d", i, sb.row_count, i / 2 + 1); else passed++;
    end
    sb.in_valid = 1'b0;
    total++; if (sb.out_valid !== 1'b1 || sb.out_matrix !== 32'h01020304)
      $display("FAIL gap_matrix got %b/%h want 1/01020304", sb.out_valid, sb.out_matrix); else passed++;
    sb.out_ready = 1'b1;
    tick();
    sb.out_ready = 1'b0;
  endtask
  task automatic test_clear;
    sb.in_valid = 1'b1;
    sb.in_row = 8'h11;
    tick();
    sb.in_row = 8'h22;
    tick();
    sb.in_row = 8'h33;
    sb.clear = 1'b1;
    tick();
    sb.clear = 1'b0;
    sb.in_valid = 1'b0;
    check_small_idle("clear");
    sb.out_ready = 1'b1;
    tick();
    sb.out_ready = 1'b0;
    check_small_idle("ready_idle");
  endtask
  task automatic test_async_reset;
    sb.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.in_row = 8'($urandom | 1);
      tick();
    end
    sb.in_valid = 1'b0;
    total++; if (sb.out_valid !== 1'b1) $display("FAIL ar_pre got %b want 1", sb.out_valid); else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    check_small_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_random;
    logic [SW-1:0] q[$];
    logic [SW-1:0] m[SR];
    logic [0:SR*SW-1] em;
    bit full;
    for (int k = 0; k < SR; k++) m[k] = '0;
    for (int c = 0; c < 400; c++) begin
      sb.in_valid = ($urandom % 4) != 0;
      sb.out_ready = ($urandom % 3) == 0;
      sb.clear = ($urandom % 40) == 0;
      sb.in_row = 8'($urandom);
      full = (q.size() == SR);
      if (sb.clear) begin
        q.delete();
        for (int k = 0; k < SR; k++) m[k] = '0;
      end else if (!full && sb.in_valid) begin
        m[q.size()] = sb.in_row;
        q.push_back(sb.in_row);
      end else if (full && sb.out_ready) q.delete();
      tick();
      for (int k = 0; k < SR; k++) em[k*SW +: SW] = m[k];
      total++; if (sb.out_valid !== (q.size() == SR) || sb.in_ready !== (q.size() != SR) || sb.row_count !== 3'(q.size()) || sb.out_matrix !== em)
        $display("FAIL rand%0d got v%b r%b n%0d %h want v%b r%b n%0d %h", c, sb.out_valid, sb.in_ready, sb.row_count, sb.out_matrix,
                 q.size() == SR, q.size() != SR, q.size(), em);
      else passed++;
    end
    sb.clear = 1'b0;
    sb.in_valid = 1'b0;
    sb.out_ready = 1'b0;
  endtask
  task automatic test_throughput;
    logic [0:BW-1] sent[$];
    logic [0:BR*BW-1] em;
    logic [0:BW-1] r;
    int mats = 0;
    bit acc;
    for (int j = 0; j < BW / 32; j++) r[j*32 +: 32] = $urandom;
    bb.in_valid = 1'b1;
    bb.out_ready = 1'b1;
    bb.in_row = r;
    for (int c = 0; c < 3 * (BR + 1); c++) begin
      acc = bb.in_ready;
      tick();
      if (acc) begin
        sent.push_back(bb.in_row);
        for (int j = 0; j < BW / 32; j++) r[j*32 +: 32] = $urandom;
        bb.in_row = r;
      end
      total++; if (bb.out_valid !== (c % (BR + 1) == BR - 1)) $display("FAIL tp_valid%0d got %b want %b", c, bb.out_valid, c % (BR + 1) == BR - 1); else passed++;
      if (bb.out_valid === 1'b1) begin
        mats++;
        if (sent.size() >= BR) begin
          for (int k = 0; k < BR; k++) em[k*BW +: BW] = sent[k];
          for (int k = 0; k < BR; k++) void'(sent.pop_front());
        end else em = '0;
        total++; if (bb.out_matrix !== em) $display("FAIL tp_matrix%0d got row0 %h want row0 %h", mats, bb.out_matrix[0:31], em[0:31]); else passed++;
      end
    end
    bb.in_valid = 1'b0;
    bb.out_ready = 1'b0;
    total++; if (mats !== 3) $display("FAIL tp_count got %0d want 3", mats); else passed++;
  endtask
  initial begin
    sb.clear = 1'b0; sb.in_valid = 1'b0; sb.in_row = '0; sb.out_ready = 1'b0;
    bb.clear = 1'b0; bb.in_valid = 1'b0; bb.in_row = '0; bb.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gapped();
    test_clear();
    test_async_reset();
    test_random();
    test_throughput();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
